// File: rtl/pong_game_ctrl_if.sv
//==============================================================================
// Module   : pong_game_ctrl_if
// Brief    : Game-controller bundle: start/ball/paddle inputs, score/state outputs.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface pong_game_ctrl_if;
  logic       i_Start;
  logic [5:0] i_Ball_X;
  logic [5:0] i_Ball_Y;
  logic [5:0] i_Paddle_Y_P1;
  logic [5:0] i_Paddle_Y_P2;
  logic       o_Game_Active;
  logic [3:0] o_P1_Score;
  logic [3:0] o_P2_Score;
  logic       o_Point_P1;
  logic       o_Point_P2;
  logic       o_Hit;
  logic [1:0] o_Winner;

  modport master (
    output i_Start, i_Ball_X, i_Ball_Y, i_Paddle_Y_P1, i_Paddle_Y_P2,
    input  o_Game_Active, o_P1_Score, o_P2_Score, o_Point_P1, o_Point_P2,
           o_Hit, o_Winner
  );

  modport slave (
    input  i_Start, i_Ball_X, i_Ball_Y, i_Paddle_Y_P1, i_Paddle_Y_P2,
    output o_Game_Active, o_P1_Score, o_P2_Score, o_Point_P1, o_Point_P2,
           o_Hit, o_Winner
  );
endinterface

`default_nettype wire

// File: rtl/pong_game_ctrl.sv
//==============================================================================
// Module   : pong_game_ctrl
// Brief    : Pong game sequencer: paddle hit/miss, scoring, serve and game over.
//            Optional macro PONG_AUTO_SERVE_EN adds a timed SERVE_WAIT phase.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module pong_game_ctrl #(
  parameter int c_GAME_WIDTH    = 40,
  parameter int c_GAME_HEIGHT   = 30,
  parameter int c_PADDLE_HEIGHT = 6,
  parameter int c_SCORE_LIMIT   = 9,
  parameter int c_SERVE_DELAY   = 25000000
) (
  input  wire logic       i_Clk,
  input  wire logic       i_Rst,
  pong_game_ctrl_if.slave bus
);

  generate
    if (c_SCORE_LIMIT < 1 || c_SCORE_LIMIT > 15 || c_GAME_WIDTH < 2 ||
        c_GAME_WIDTH > 64 || c_GAME_HEIGHT < 1 || c_GAME_HEIGHT > 64 ||
        c_PADDLE_HEIGHT < 1 || c_SERVE_DELAY < 1) begin : g_bad_params
      $error("pong_game_ctrl: parameter out of range");
    end
  endgenerate

  localparam logic [5:0] c_RIGHT_COL = 6'(c_GAME_WIDTH - 1);
  localparam logic [3:0] c_LIMIT     = 4'(c_SCORE_LIMIT);
  localparam logic [6:0] c_PAD_SPAN  = 7'(c_PADDLE_HEIGHT - 1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RUNNING    = 3'd1,
    ST_POINT      = 3'd2,
`ifdef PONG_AUTO_SERVE_EN
    ST_SERVE_WAIT = 3'd4,
`endif
    ST_GAME_OVER  = 3'd3
  } state_t;

  state_t     r_state, w_state_next;
  logic       r_start_prev;
  logic [5:0] r_ball_x_prev, w_ball_x_prev_next;
  logic [5:0] r_ball_y_prev, w_ball_y_prev_next;
  logic       r_game_active;
  logic [3:0] r_p1_score, w_p1_score_next;
  logic [3:0] r_p2_score, w_p2_score_next;
  logic       r_point_p1, w_point_p1_next;
  logic       r_point_p2, w_point_p2_next;
  logic       r_hit, w_hit_next;
  logic [1:0] r_winner, w_winner_next;
`ifdef PONG_AUTO_SERVE_EN
  localparam logic [31:0] c_SERVE_LAST = 32'(c_SERVE_DELAY - 1);
  logic [31:0] r_serve_cnt, w_serve_cnt_next;
`endif

  logic       w_start_evt;
  logic       w_move_evt;
  logic       w_in_p1;
  logic       w_in_p2;
  logic [6:0] w_ball_y7;
  logic [6:0] w_p1_top, w_p2_top;

  assign w_start_evt = bus.i_Start && !r_start_prev;
  assign w_move_evt  = (bus.i_Ball_X != r_ball_x_prev) || (bus.i_Ball_Y != r_ball_y_prev);

  // 7-bit compare keeps a paddle hanging past the bottom row from wrapping.
  assign w_ball_y7 = {1'b0, bus.i_Ball_Y};
  assign w_p1_top  = {1'b0, bus.i_Paddle_Y_P1};
  assign w_p2_top  = {1'b0, bus.i_Paddle_Y_P2};
  assign w_in_p1   = (w_ball_y7 >= w_p1_top) && (w_ball_y7 <= w_p1_top + c_PAD_SPAN);
  assign w_in_p2   = (w_ball_y7 >= w_p2_top) && (w_ball_y7 <= w_p2_top + c_PAD_SPAN);

  always_comb begin
    w_state_next       = r_state;
    w_ball_x_prev_next = r_ball_x_prev;
    w_ball_y_prev_next = r_ball_y_prev;
    w_p1_score_next    = r_p1_score;
    w_p2_score_next    = r_p2_score;
    w_point_p1_next    = 1'b0;
    w_point_p2_next    = 1'b0;
    w_hit_next         = 1'b0;
    w_winner_next      = r_winner;
`ifdef PONG_AUTO_SERVE_EN
    w_serve_cnt_next   = '0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_start_evt) begin
          w_state_next       = ST_RUNNING;
          w_ball_x_prev_next = bus.i_Ball_X;
          w_ball_y_prev_next = bus.i_Ball_Y;
        end
      end
      ST_RUNNING: begin
        if (w_move_evt) begin
          w_ball_x_prev_next = bus.i_Ball_X;
          w_ball_y_prev_next = bus.i_Ball_Y;
          if (bus.i_Ball_X == 6'd0) begin
            if (w_in_p1) begin
              w_hit_next = 1'b1;
            end else begin
              w_p2_score_next = r_p2_score + 4'd1;
              w_point_p2_next = 1'b1;
              w_state_next    = ST_POINT;
            end
          end else if (bus.i_Ball_X == c_RIGHT_COL) begin
            if (w_in_p2) begin
              w_hit_next = 1'b1;
            end else begin
              w_p1_score_next = r_p1_score + 4'd1;
              w_point_p1_next = 1'b1;
              w_state_next    = ST_POINT;
            end
          end
        end
      end
      ST_POINT: begin
        if (r_p1_score == c_LIMIT) begin
          w_winner_next = 2'd1;
          w_state_next  = ST_GAME_OVER;
        end else if (r_p2_score == c_LIMIT) begin
          w_winner_next = 2'd2;
          w_state_next  = ST_GAME_OVER;
        end else begin
`ifdef PONG_AUTO_SERVE_EN
          w_state_next = ST_SERVE_WAIT;
`else
          w_state_next = ST_IDLE;
`endif
        end
      end
`ifdef PONG_AUTO_SERVE_EN
      ST_SERVE_WAIT: begin
        if (w_start_evt || (r_serve_cnt == c_SERVE_LAST)) begin
          w_state_next       = ST_RUNNING;
          w_ball_x_prev_next = bus.i_Ball_X;
          w_ball_y_prev_next = bus.i_Ball_Y;
        end else begin
          w_serve_cnt_next = r_serve_cnt + 32'd1;
        end
      end
`endif
      ST_GAME_OVER: begin
        if (w_start_evt) begin
          w_p1_score_next = 4'd0;
          w_p2_score_next = 4'd0;
          w_winner_next   = 2'd0;
          w_state_next    = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state       <= ST_IDLE;
      r_start_prev  <= 1'b1;
      r_ball_x_prev <= 6'd0;
      r_ball_y_prev <= 6'd0;
      r_game_active <= 1'b0;
      r_p1_score    <= 4'd0;
      r_p2_score    <= 4'd0;
      r_point_p1    <= 1'b0;
      r_point_p2    <= 1'b0;
      r_hit         <= 1'b0;
      r_winner      <= 2'd0;
`ifdef PONG_AUTO_SERVE_EN
      r_serve_cnt   <= 32'd0;
`endif
    end else begin
      r_state       <= w_state_next;
      r_start_prev  <= bus.i_Start;
      r_ball_x_prev <= w_ball_x_prev_next;
      r_ball_y_prev <= w_ball_y_prev_next;
      r_game_active <= (w_state_next == ST_RUNNING);
      r_p1_score    <= w_p1_score_next;
      r_p2_score    <= w_p2_score_next;
      r_point_p1    <= w_point_p1_next;
      r_point_p2    <= w_point_p2_next;
      r_hit         <= w_hit_next;
      r_winner      <= w_winner_next;
`ifdef PONG_AUTO_SERVE_EN
      r_serve_cnt   <= w_serve_cnt_next;
`endif
    end
  end

  assign bus.o_Game_Active = r_game_active;
  assign bus.o_P1_Score    = r_p1_score;
  assign bus.o_P2_Score    = r_p2_score;
  assign bus.o_Point_P1    = r_point_p1;
  assign bus.o_Point_P2    = r_point_p2;
  assign bus.o_Hit         = r_hit;
  assign bus.o_Winner      = r_winner;

endmodule

`default_nettype wire
